// File: rtl/alu_pipe_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | alu_pipe_pkg : opcode and multiplier-state types for alu_pipe            |
// | Config macro : ALU_MUL_EN (enables opcode 11, iterative MUL)             |
// | Revision     : 1.0                                                       |
// +--------------------------------------------------------------------------+
package alu_pipe_pkg;

    typedef enum logic [3:0] {
        OP_AND  = 4'd0,
        OP_OR   = 4'd1,
        OP_NOT  = 4'd2,
        OP_ADD  = 4'd3,
        OP_SUB  = 4'd4,
        OP_SLL  = 4'd5,
        OP_SRL  = 4'd6,
        OP_SRA  = 4'd7,
        OP_SLT  = 4'd8,
        OP_SLTU = 4'd9,
        OP_XOR  = 4'd10,
        OP_MUL  = 4'd11
    } alu_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } mul_state_t;

`ifdef ALU_MUL_EN
    localparam logic [3:0] OP_LAST_LEGAL = 4'd11;
`else
    localparam logic [3:0] OP_LAST_LEGAL = 4'd10;
`endif

endpackage

`default_nettype wire

// File: rtl/alu_pipe_mul.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | alu_pipe_mul : unsigned shift-add multiplier, one bit per cycle          |
// | Config macro : ALU_MUL_EN (only instantiated when defined)               |
// | Revision     : 1.0                                                       |
// +--------------------------------------------------------------------------+
module alu_pipe_mul #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_start,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic             o_last,
    output logic [WIDTH-1:0] o_p
);

    localparam int c_CNT_W = $clog2(WIDTH);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(WIDTH - 1);

    logic               r_busy;
    logic [c_CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0]   r_mcand;
    logic [WIDTH-1:0]   r_mplier;
    logic [WIDTH-1:0]   r_acc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy   <= 1'b0;
            r_cnt    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_acc    <= '0;
        end else if (i_start) begin
            r_busy   <= 1'b1;
            r_cnt    <= '0;
            r_mcand  <= i_a;
            r_mplier <= i_b;
            r_acc    <= '0;
        end else if (r_busy) begin
            // Only the low WIDTH bits of the product are kept, so the shifted
            // multiplicand may simply fall off the top.
            if (r_mplier[0]) begin
                r_acc <= r_acc + r_mcand;
            end
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_cnt    <= r_cnt + 1'b1;
            if (r_cnt == c_CNT_LAST) begin
                r_busy <= 1'b0;
            end
        end
    end

    assign o_last = r_busy && (r_cnt == c_CNT_LAST);
    assign o_p    = r_acc;

endmodule

`default_nettype wire

// File: rtl/alu_pipe.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | alu_pipe     : two-stage valid/ready ALU with in-order tagged results    |
// | Config macro : ALU_MUL_EN (adds iterative MUL, opcode 11)                |
// | Revision     : 1.0                                                       |
// +--------------------------------------------------------------------------+
module alu_pipe
    import alu_pipe_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       in_op,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_f,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_zero,
    output logic             out_err
);

    localparam int c_SH_W = $clog2(WIDTH);

    logic             r_s1_valid;
    logic [3:0]       r_s1_op;
    logic [WIDTH-1:0] r_s1_a;
    logic [WIDTH-1:0] r_s1_b;
    logic [TAG_W-1:0] r_s1_tag;

    logic             r_s2_valid;
    logic [WIDTH-1:0] r_s2_f;
    logic [TAG_W-1:0] r_s2_tag;
    logic             r_s2_zero;
    logic             r_s2_err;

    logic              w_s1_done;
    logic              w_s1_idle;
    logic              w_s2_free;
    logic              w_s1_move;
    logic              w_accept;
    logic [c_SH_W-1:0] w_shamt;
    logic [WIDTH-1:0]  w_f;
    logic              w_err;

    assign w_s2_free = !r_s2_valid || out_ready;
    assign w_s1_move = r_s1_valid && w_s1_done && w_s2_free;
    assign in_ready  = rst_n && (!r_s1_valid || (w_s1_idle && w_s2_free));
    assign w_accept  = in_valid && in_ready;
    assign w_shamt   = r_s1_b[c_SH_W-1:0];

`ifdef ALU_MUL_EN
    mul_state_t       r_state;
    mul_state_t       w_state_nxt;
    logic             w_mul_start;
    logic             w_mul_last;
    logic [WIDTH-1:0] w_mul_p;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_mul_start = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_accept && (in_op == OP_MUL)) begin
                    w_mul_start = 1'b1;
                    w_state_nxt = BUSY;
                end
            end
            BUSY: begin
                if (w_mul_last) begin
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                if (w_s2_free) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // A MUL holds S1 until it has left for S2, so nothing new enters in DONE.
    assign w_s1_done = (r_state != BUSY);
    assign w_s1_idle = (r_state == IDLE);

    alu_pipe_mul #(
        .WIDTH (WIDTH)
    ) u_mul (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_start (w_mul_start),
        .i_a     (in_a),
        .i_b     (in_b),
        .o_last  (w_mul_last),
        .o_p     (w_mul_p)
    );
`else
    assign w_s1_done = 1'b1;
    assign w_s1_idle = 1'b1;
`endif

    always_comb begin
        w_f   = '0;
        w_err = 1'b0;
        if (r_s1_op > OP_LAST_LEGAL) begin
            w_err = 1'b1;
        end else begin
            case (r_s1_op)
                OP_AND:  w_f = r_s1_a & r_s1_b;
                OP_OR:   w_f = r_s1_a | r_s1_b;
                OP_NOT:  w_f = ~r_s1_a;
                OP_ADD:  w_f = r_s1_a + r_s1_b;
                OP_SUB:  w_f = r_s1_a - r_s1_b;
                OP_SLL:  w_f = r_s1_a << w_shamt;
                OP_SRL:  w_f = r_s1_a >> w_shamt;
                OP_SRA:  w_f = $signed(r_s1_a) >>> w_shamt;
                OP_SLT:  w_f = {{(WIDTH-1){1'b0}}, ($signed(r_s1_a) < $signed(r_s1_b))};
                OP_SLTU: w_f = {{(WIDTH-1){1'b0}}, (r_s1_a < r_s1_b)};
                OP_XOR:  w_f = r_s1_a ^ r_s1_b;
`ifdef ALU_MUL_EN
                OP_MUL:  w_f = w_mul_p;
`endif
                default: w_err = 1'b1;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_s1_op    <= '0;
            r_s1_a     <= '0;
            r_s1_b     <= '0;
            r_s1_tag   <= '0;
        end else if (w_accept) begin
            r_s1_valid <= 1'b1;
            r_s1_op    <= in_op;
            r_s1_a     <= in_a;
            r_s1_b     <= in_b;
            r_s1_tag   <= in_tag;
        end else if (w_s1_move) begin
            r_s1_valid <= 1'b0;
        end
    end

    // Result fields only change on a load, so they stay stable under backpressure.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s2_valid <= 1'b0;
            r_s2_f     <= '0;
            r_s2_tag   <= '0;
            r_s2_zero  <= 1'b0;
            r_s2_err   <= 1'b0;
        end else if (w_s1_move) begin
            r_s2_valid <= 1'b1;
            r_s2_f     <= w_f;
            r_s2_tag   <= r_s1_tag;
            r_s2_zero  <= (w_f == '0);
            r_s2_err   <= w_err;
        end else if (out_ready) begin
            r_s2_valid <= 1'b0;
        end
    end

    assign out_valid = r_s2_valid;
    assign out_f     = r_s2_f;
    assign out_tag   = r_s2_tag;
    assign out_zero  = r_s2_zero;
    assign out_err   = r_s2_err;

endmodule

`default_nettype wire

// File: tb/tb_alu_pipe.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_alu_pipe : directed scoreboard bench for alu_pipe (WIDTH=32, TAG_W=4) |
// | Config macro : ALU_MUL_EN selects MUL expectations                       |
// | Revision     : 1.0                                                       |
// +--------------------------------------------------------------------------+
module tb_alu_pipe;

    localparam int W  = 32;
    localparam int TW = 4;

    logic          clk       = 1'b0;
    logic          rst_n     = 1'b0;
    logic          in_valid  = 1'b0;
    logic          out_ready = 1'b1;
    logic [3:0]    in_op     = '0;
    logic [W-1:0]  in_a      = '0;
    logic [W-1:0]  in_b      = '0;
    logic [TW-1:0] in_tag    = '0;
    logic          in_ready;
    logic          out_valid;
    logic [W-1:0]  out_f;
    logic [TW-1:0] out_tag;
    logic          out_zero;
    logic          out_err;

    typedef struct {
        logic [W-1:0]  f;
        logic [TW-1:0] tag;
        logic          zero;
        logic          err;
        int            cyc;
    } res_t;

    res_t exp_q[$];
    res_t got_q[$];
    int   checks  = 0;
    int   errors  = 0;
    int   cyc_cnt = 0;

    alu_pipe #(
        .WIDTH (W),
        .TAG_W (TW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_op     (in_op),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_f     (out_f),
        .out_tag   (out_tag),
        .out_zero  (out_zero),
        .out_err   (out_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    // Inputs change just after posedge; a result transfers at the next posedge iff valid && ready mid-cycle.
    always @(negedge clk) begin : mon
        res_t g;
        if (rst_n && out_valid && out_ready) begin
            g.f    = out_f;
            g.tag  = out_tag;
            g.zero = out_zero;
            g.err  = out_err;
            g.cyc  = cyc_cnt;
            got_q.push_back(g);
        end
    end

    task automatic check(input string name, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", name, obs, expv);
        end
    endtask

    function automatic logic [W:0] model(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] f;
        logic         e;
        f = '0;
        e = 1'b0;
        case (op)
            4'd0:  f = a & b;
            4'd1:  f = a | b;
            4'd2:  f = ~a;
            4'd3:  f = a + b;
            4'd4:  f = a - b;
            4'd5:  f = a << b[4:0];
            4'd6:  f = a >> b[4:0];
            4'd7:  f = $signed(a) >>> b[4:0];
            4'd8:  f = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'd9:  f = (a < b) ? 32'd1 : 32'd0;
            4'd10: f = a ^ b;
`ifdef ALU_MUL_EN
            4'd11: f = a * b;
`endif
            default: e = 1'b1;
        endcase
        return {e, f};
    endfunction

    task automatic send(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [TW-1:0] tag, input logic [W-1:0] ef, input logic ee);
        res_t e;
        int   n;
        in_valid = 1'b1;
        in_op    = op;
        in_a     = a;
        in_b     = b;
        in_tag   = tag;
        n        = 0;
        @(negedge clk);
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            in_valid = 1'b0;
            check("send_timeout", 64'd0, 64'd1);
        end else begin
            e.f    = ef;
            e.tag  = tag;
            e.zero = (ef == '0);
            e.err  = ee;
            e.cyc  = 0;
            exp_q.push_back(e);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic send_m(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [TW-1:0] tag);
        logic [W:0] m;
        m = model(op, a, b);
        send(op, a, b, tag, m[W-1:0], m[W]);
    endtask

    task automatic wait_got(input int k);
        int n;
        n = 0;
        while (got_q.size() < k && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
    endtask

    task automatic drain(input string nm);
        res_t g;
        res_t e;
        wait_got(exp_q.size());
        check({nm, ".count"}, 64'(got_q.size()), 64'(exp_q.size()));
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            e = exp_q.pop_front();
            g = got_q.pop_front();
            check({nm, ".f"},    64'(g.f),    64'(e.f));
            check({nm, ".tag"},  64'(g.tag),  64'(e.tag));
            check({nm, ".zero"}, 64'(g.zero), 64'(e.zero));
            check({nm, ".err"},  64'(g.err),  64'(e.err));
        end
        exp_q.delete();
        got_q.delete();
    endtask

    initial begin : stim
        int n;
        int bad;

        // Reset state
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst.in_ready",  64'(in_ready),  64'd0);
        check("rst.out_valid", 64'(out_valid), 64'd0);
        check("rst.out_f",     64'(out_f),     64'd0);
        check("rst.out_tag",   64'(out_tag),   64'd0);
        check("rst.out_zero",  64'(out_zero),  64'd0);
        check("rst.out_err",   64'(out_err),   64'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("post_rst.in_ready", 64'(in_ready), 64'd1);

        // ADD wrap to zero, one-cycle latency after acceptance
        send(4'd3, 32'hFFFF_FFFF, 32'd1, 4'd3, 32'd0, 1'b0);
        check("t1.valid_at_accept", 64'(out_valid), 64'd0);
        @(posedge clk);
        #1;
        check("t1.valid_next", 64'(out_valid), 64'd1);
        drain("t1");

        // Back-to-back SUB, SRA, SLTU on consecutive cycles
        send(4'd4, 32'd5, 32'd7, 4'd1, 32'hFFFF_FFFE, 1'b0);
        send(4'd7, 32'h8000_0000, 32'd4, 4'd2, 32'hF800_0000, 1'b0);
        send(4'd9, 32'd1, 32'd2, 4'd4, 32'd1, 1'b0);
        wait_got(3);
        if (got_q.size() >= 3) begin
            check("t2.gap01", 64'(got_q[1].cyc - got_q[0].cyc), 64'd1);
            check("t2.gap12", 64'(got_q[2].cyc - got_q[1].cyc), 64'd1);
        end else begin
            check("t2.outputs", 64'(got_q.size()), 64'd3);
        end
        drain("t2");

        // Backpressure: two queued, in_ready low, outputs stable
        out_ready = 1'b0;
        send(4'd0, 32'hF0F0_1234, 32'hFF00_FF00, 4'd5, 32'hF000_1200, 1'b0);
        send(4'd1, 32'h0000_00F0, 32'h0000_000F, 4'd6, 32'h0000_00FF, 1'b0);
        in_valid = 1'b1;
        in_op    = 4'd10;
        in_a     = 32'hAAAA_5555;
        in_b     = 32'hFFFF_0000;
        in_tag   = 4'd7;
        for (int i = 0; i < 5; i++) begin
            check("t3.in_ready",  64'(in_ready),  64'd0);
            check("t3.out_valid", 64'(out_valid), 64'd1);
            check("t3.out_f",     64'(out_f),     64'hF000_1200);
            check("t3.out_tag",   64'(out_tag),   64'd5);
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        send(4'd10, 32'hAAAA_5555, 32'hFFFF_0000, 4'd7, 32'h5555_5555, 1'b0);
        drain("t3");

        // Illegal opcodes, then normal ops continue
        send(4'hF, 32'h5A, 32'h5A, 4'd8, 32'd0, 1'b1);
        send(4'd10, 32'h0000_00FF, 32'h0000_000F, 4'd9, 32'h0000_00F0, 1'b0);
        send(4'hC, 32'h1234, 32'h1, 4'd1, 32'd0, 1'b1);
        send(4'd8, 32'hFFFF_FFFF, 32'd1, 4'd2, 32'd1, 1'b0);
        send(4'd9, 32'hFFFF_FFFF, 32'd1, 4'd3, 32'd0, 1'b0);
        send(4'd5, 32'h0000_0001, 32'd31, 4'd4, 32'h8000_0000, 1'b0);
        send(4'd6, 32'h8000_0000, 32'd35, 4'd5, 32'h1000_0000, 1'b0);
        send(4'd2, 32'h0F0F_0F0F, 32'd0, 4'd6, 32'hF0F0_F0F0, 1'b0);
        drain("t4");

        // Model-checked sweep over every legal single-cycle op
        for (int op = 0; op <= 10; op++) begin
            send_m(4'(op), $urandom, $urandom, 4'(op));
        end
        drain("sweep");

`ifdef ALU_MUL_EN
        send(4'd11, 32'd1234, 32'd5678, 4'd10, 32'd7006652, 1'b0);
        n   = 0;
        bad = 0;
        while (!out_valid && n < 100) begin
            if (in_ready) bad++;
            @(posedge clk);
            #1;
            n++;
        end
        check("t5.latency", 64'(n), 64'd33);
        check("t5.ready_low", 64'(bad), 64'd0);
        drain("t5");
        send(4'd11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'd11, 32'd1, 1'b0);
        drain("t5b");
`else
        send(4'd11, 32'd1234, 32'd5678, 4'd10, 32'd0, 1'b1);
        drain("t5");
`endif

        // Reset mid-operation with a result held at the output
        out_ready = 1'b0;
        send_m(4'd3, 32'd10, 32'd20, 4'd11);
        send_m(4'd11, 32'd3, 32'd4, 4'd12);
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        check("t6.held_valid", 64'(out_valid), 64'd1);
        rst_n = 1'b0;
        #1;
        check("t6.rst_valid",    64'(out_valid), 64'd0);
        check("t6.rst_f",        64'(out_f),     64'd0);
        check("t6.rst_tag",      64'(out_tag),   64'd0);
        check("t6.rst_zero",     64'(out_zero),  64'd0);
        check("t6.rst_err",      64'(out_err),   64'd0);
        check("t6.rst_in_ready", 64'(in_ready),  64'd0);
        exp_q.delete();
        got_q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n     = 1'b1;
        out_ready = 1'b1;
        repeat (40) begin
            @(posedge clk);
            #1;
        end
        check("t6.no_stale", 64'(got_q.size()), 64'd0);
        check("t6.idle_valid", 64'(out_valid), 64'd0);
        send(4'd4, 32'd100, 32'd1, 4'd13, 32'd99, 1'b0);
        drain("t6_after");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
